// File: rtl/qpsk_mapper.sv
// QPSK mapper: pairs the serial interleaved bit stream into Gray-coded Q1.15 I/Q symbols,
// counts symbols per block and buffers them in a small valid/ready output FIFO.
module qpsk_mapper #(
  parameter int NCBPS      = 192,
  parameter int W          = 16,
  parameter int AMP        = 23170,
  parameter int FIFO_DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         data_in,
  input  logic [7:0]   data_index,
  input  logic         valid_in,
  output logic         ready_out,
  output logic [W-1:0] i_out,
  output logic [W-1:0] q_out,
  output logic [6:0]   sym_index,
  output logic         last_out,
  output logic         valid_out,
  input  logic         ready_in,
  output logic         align_err
);

  localparam int NSYM = NCBPS / 2;
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CW   = AW + 1;
  localparam logic [W-1:0] POS = W'(AMP);
  localparam logic [W-1:0] NEG = W'(-AMP);

  typedef enum logic {PH_B0, PH_B1} phase_t;

  typedef struct packed {
    logic       b0;
    logic       b1;
    logic [6:0] idx;
    logic       last;
  } entry_t;

  phase_t        state_q, state_d;
  logic          b0_q;
  logic [6:0]    sym_cnt;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  entry_t        mem [FIFO_DEPTH];
  entry_t        head;

  logic accept, pop, push, latch_b0, set_err, clr_cnt;

  assign ready_out = (count < CW'(FIFO_DEPTH));
  assign valid_out = (count != '0);
  assign accept    = valid_in && ready_out;
  assign pop       = valid_out && ready_in;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    latch_b0 = 1'b0;
    push     = 1'b0;
    set_err  = 1'b0;
    clr_cnt  = 1'b0;
    if (accept) begin
      if (data_index == 8'd0) begin
        // Block start always begins a new pair; a half-built pair means we lost sync.
        latch_b0 = 1'b1;
        state_d  = PH_B1;
        if (state_q == PH_B1) begin
          set_err = 1'b1;
          clr_cnt = 1'b1;
        end
      end else if (state_q == PH_B0) begin
        if (data_index[0]) begin
          set_err = 1'b1;
        end else begin
          latch_b0 = 1'b1;
          state_d  = PH_B1;
        end
      end else begin
        push    = 1'b1;
        state_d = PH_B0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= PH_B0;
      b0_q      <= 1'b0;
      sym_cnt   <= '0;
      align_err <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
    end else begin
      state_q <= state_d;
      if (latch_b0) b0_q <= data_in;
      if (set_err)  align_err <= 1'b1;
      if (clr_cnt)
        sym_cnt <= '0;
      else if (push)
        sym_cnt <= (sym_cnt == 7'(NSYM - 1)) ? 7'd0 : sym_cnt + 7'd1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: storage is not reset; outputs are gated by valid_out so stale entries never leak.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{b0: b0_q, b1: data_in, idx: sym_cnt,
                               last: (sym_cnt == 7'(NSYM - 1))};
  end

  assign head      = mem[rd_ptr];
  assign i_out     = valid_out ? (head.b0 ? NEG : POS) : '0;
  assign q_out     = valid_out ? (head.b1 ? NEG : POS) : '0;
  assign sym_index = valid_out ? head.idx : 7'd0;
  assign last_out  = valid_out && head.last;

endmodule

// File: tb/tb_qpsk_mapper.sv
// Directed bench for qpsk_mapper: hand-computed symbol checks plus a bit-level reference model
// that scoreboards every popped symbol.
module tb_qpsk_mapper;

  localparam logic [15:0] POS = 16'h5A82;
  localparam logic [15:0] NEG = 16'hA57E;

  logic        clk = 1'b0;
  logic        reset;
  logic        data_in;
  logic [7:0]  data_index;
  logic        valid_in;
  logic        ready_out;
  logic [15:0] i_out, q_out;
  logic [6:0]  sym_index;
  logic        last_out, valid_out;
  logic        ready_in;
  logic        align_err;

  qpsk_mapper dut (
    .clk(clk), .reset(reset), .data_in(data_in), .data_index(data_index),
    .valid_in(valid_in), .ready_out(ready_out), .i_out(i_out), .q_out(q_out),
    .sym_index(sym_index), .last_out(last_out), .valid_out(valid_out),
    .ready_in(ready_in), .align_err(align_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] i;
    logic [15:0] q;
    logic [6:0]  idx;
    logic        last;
  } sym_t;

  sym_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   n_pop  = 0;
  int   n_last = 0;

  // reference model state
  logic       m_ph;
  logic       m_b0;
  logic [6:0] m_cnt;
  logic       m_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_ph  = 1'b0;
    m_b0  = 1'b0;
    m_cnt = 7'd0;
    m_err = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_accept(input logic b, input logic [7:0] idx);
    sym_t e;
    if (idx == 8'd0) begin
      if (m_ph) begin
        m_err = 1'b1;
        m_cnt = 7'd0;
      end
      m_b0 = b;
      m_ph = 1'b1;
    end else if (!m_ph) begin
      if (idx[0]) m_err = 1'b1;
      else begin
        m_b0 = b;
        m_ph = 1'b1;
      end
    end else begin
      e.i    = m_b0 ? NEG : POS;
      e.q    = b ? NEG : POS;
      e.idx  = m_cnt;
      e.last = (m_cnt == 7'd95);
      exp_q.push_back(e);
      m_cnt  = (m_cnt == 7'd95) ? 7'd0 : m_cnt + 7'd1;
      m_ph   = 1'b0;
    end
  endtask

  // Present one bit and hold it until the DUT accepts it (bounded).
  task automatic send_bit(input logic b, input logic [7:0] idx);
    logic rdy;
    bit   done = 0;
    valid_in   = 1'b1;
    data_in    = b;
    data_index = idx;
    for (int n = 0; n < 50 && !done; n++) begin
      rdy = ready_out;
      tick();
      if (rdy) done = 1;
    end
    if (!done) check("accept_timeout", 0, 1);
    else begin
      model_accept(b, idx);
      check("align_err", align_err, m_err);
    end
  endtask

  task automatic idle();
    valid_in = 1'b0;
  endtask

  task automatic pop_one();
    ready_in = 1'b1;
    tick();
    ready_in = 1'b0;
  endtask

  task automatic pop_check(input logic [15:0] ei, input logic [15:0] eq, input logic [6:0] es,
                           input logic el);
    check("hc_valid", valid_out, 1);
    check("hc_i", i_out, ei);
    check("hc_q", q_out, eq);
    check("hc_sym", sym_index, es);
    check("hc_last", last_out, el);
    pop_one();
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    model_reset();
    repeat (cycles) tick();
    reset = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, valid_out, 0);
    check({tag, "_ready"}, ready_out, 1);
    check({tag, "_i"}, i_out, 0);
    check({tag, "_q"}, q_out, 0);
    check({tag, "_sym"}, sym_index, 0);
    check({tag, "_last"}, last_out, 0);
    check({tag, "_err"}, align_err, 0);
  endtask

  // Scoreboard: a pop happens at the next rising edge whenever valid_out && ready_in here.
  always @(negedge clk) begin
    sym_t e;
    if (!reset && valid_out && ready_in) begin
      if (exp_q.size() == 0) check("unexpected_pop", 1, 0);
      else begin
        e = exp_q.pop_front();
        check("pop_i", i_out, e.i);
        check("pop_q", q_out, e.q);
        check("pop_sym", sym_index, e.idx);
        check("pop_last", last_out, e.last);
        n_pop++;
        if (last_out) n_last++;
      end
    end
  end

  initial begin
    valid_in   = 1'b0;
    data_in    = 1'b0;
    data_index = 8'd0;
    ready_in   = 1'b0;
    reset      = 1'b1;
    model_reset();
    tick();
    do_reset(3);
    check_idle("por");

    // T1: reset mid-pair with two symbols buffered
    send_bit(0, 0); send_bit(1, 1); send_bit(1, 2); send_bit(0, 3); send_bit(1, 4);
    idle();
    check("t1_pre_valid", valid_out, 1);
    do_reset(3);
    check_idle("t1");
    tick();
    check_idle("t1_next");

    // T2: mapping of all four dibits, FIFO filled then drained by hand
    send_bit(0, 0); send_bit(0, 1);
    send_bit(0, 2); send_bit(1, 3);
    send_bit(1, 4); send_bit(0, 5);
    send_bit(1, 6); send_bit(1, 7);
    idle();
    check("t2_full_ready", ready_out, 0);
    pop_check(POS, POS, 7'd0, 0);
    pop_check(POS, NEG, 7'd1, 0);
    pop_check(NEG, POS, 7'd2, 0);
    pop_check(NEG, NEG, 7'd3, 0);
    check("t2_empty", valid_out, 0);

    // T3: two back-to-back random blocks
    model_reset();
    do_reset(2);
    n_pop    = 0;
    n_last   = 0;
    ready_in = 1'b1;
    for (int blk = 0; blk < 2; blk++)
      for (int k = 0; k < 192; k++)
        send_bit(1'($urandom_range(0, 1)), 8'(k));
    idle();
    repeat (10) tick();
    check("t3_pops", n_pop, 192);
    check("t3_lasts", n_last, 2);
    check("t3_drained", exp_q.size(), 0);
    check("t3_err", align_err, 0);

    // T4: backpressure, then simultaneous push/pop at count 3
    ready_in = 1'b0;
    for (int k = 0; k < 8; k++) send_bit(1'($urandom_range(0, 1)), 8'(k));
    check("t4_full_ready", ready_out, 0);
    valid_in   = 1'b1;
    data_in    = 1'b1;
    data_index = 8'd8;
    repeat (18) tick();
    check("t4_hold_ready", ready_out, 0);
    check("t4_hold_i", i_out, exp_q[0].i);
    check("t4_hold_q", q_out, exp_q[0].q);
    check("t4_hold_sym", sym_index, exp_q[0].idx);
    pop_one();
    send_bit(1, 8);
    ready_in = 1'b1;
    send_bit(0, 9);
    ready_in = 1'b0;
    check("t4_pushpop_ready", ready_out, 1);
    send_bit(1, 10); send_bit(1, 11);
    idle();
    check("t4_refull_ready", ready_out, 0);
    ready_in = 1'b1;
    repeat (10) tick();
    ready_in = 1'b0;
    check("t4_drained", exp_q.size(), 0);
    check("t4_empty", valid_out, 0);

    // T5: block start arrives while a b0 is pending
    send_bit(0, 0); send_bit(0, 1); send_bit(0, 2); send_bit(0, 3);
    send_bit(0, 4); send_bit(0, 5); send_bit(1, 6);
    check("t5_err_before", align_err, 0);
    send_bit(1, 0);
    check("t5_err_after", align_err, 1);
    send_bit(0, 1);
    idle();
    pop_one(); pop_one(); pop_one();
    pop_check(NEG, POS, 7'd0, 0);
    check("t5_empty", valid_out, 0);

    // T6: odd index in PH_B0 is dropped
    do_reset(2);
    send_bit(0, 0); send_bit(1, 1);
    send_bit(1, 5);
    check("t6_err", align_err, 1);
    send_bit(1, 2); send_bit(0, 3);
    idle();
    pop_check(POS, NEG, 7'd0, 0);
    pop_check(NEG, POS, 7'd1, 0);
    check("t6_no_extra", valid_out, 0);
    check("t6_err_sticky", align_err, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
